// File: rtl/rrp_otf_convert.sv
// rrp_otf_convert: MSD-first redundant signed-digit to two's complement conversion using on-the-fly Q/QM registers.
// Latency NDIG clocks from accept to out_valid; the result is held until out_ready, then accepts a new word in the same cycle.
// Optional out-of-range digit check is enabled by defining RRP_OTF_DIGIT_CHECK_EN.
module rrp_otf_convert #(
  parameter  int WIDTH = 7,
  parameter  int RADIX = 2,
  localparam int NDIG  = 2*WIDTH+1,
  localparam int L     = $clog2(RADIX),
  localparam int D     = L+1,
  localparam int B     = NDIG*L+1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [D*NDIG-1:0] p_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [B-1:0]      q_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_out
);

  localparam int CW = $clog2(NDIG+1);
  localparam logic [CW-1:0] LAST = CW'(NDIG-1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [D*NDIG-1:0]  sreg;
  logic [B-1:0]       q, qm, q_src, qm_src, q_nxt, qm_nxt;
  logic [CW-1:0]      cnt;
  logic [D-1:0]       dig;
  logic               dig_neg, dig_pos;
  logic [L-1:0]       f_q, f_qm;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: if (cnt == LAST) state_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? CONV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid & in_ready;
  end

  // The appended L-bit field is d mod r for Q' and (d-1) mod r for QM', whichever register is the source.
  assign dig     = sreg[D*NDIG-1 -: D];
  assign dig_neg = dig[D-1];
  assign dig_pos = !dig[D-1] && (dig[L-1:0] != '0);
  assign f_q     = dig[L-1:0];
  assign f_qm    = dig[L-1:0] - L'(1);
  assign q_src   = dig_neg ? qm : q;
  assign qm_src  = dig_pos ? q : qm;
  assign q_nxt   = (q_src  << L) | B'(f_q);
  assign qm_nxt  = (qm_src << L) | B'(f_qm);

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg      <= '0;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      sreg      <= p_in;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == CONV) begin
      sreg <= {sreg[D*NDIG-D-1:0], {D{1'b0}}};
      q    <= q_nxt;
      qm   <= qm_nxt;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) begin
        q_out     <= q_nxt;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RRP_OTF_DIGIT_CHECK_EN
  // -RADIX is the only code a D-bit digit can hold outside the legal digit set.
  logic err_q;
  always_ff @(posedge clock) begin
    if (reset || accept)
      err_q <= 1'b0;
    else if (state == CONV && dig == {1'b1, {L{1'b0}}})
      err_q <= 1'b1;
  end
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule
